// File: rtl/hex_display_ctrl.sv
// Multi-digit hex seven-segment controller: captures a value on load and drives
// both per-digit static segment outputs and a time-multiplexed scan bus.
module hex_display_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  lz_en,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink_en,
    output logic [7*DIGITS-1:0]   hex_seg,
    output logic [DIGITS-1:0]     hex_dp_n,
    output logic [6:0]            seg_mux,
    output logic                  dp_mux_n,
    output logic [DIGITS-1:0]     an_n
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [7*DIGITS-1:0] seg_q, seg_d;
    logic [DIGITS-1:0]   dp_n_q, dp_n_d;
    logic [6:0]          seg_mux_q, seg_mux_d;
    logic                dp_mux_q, dp_mux_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                scan_wrap, blink_wrap;
    logic                zero_run, lz_blank, bl_blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'h0: decode = 7'b0000001;
            4'h1: decode = 7'b1001111;
            4'h2: decode = 7'b0010010;
            4'h3: decode = 7'b0000110;
            4'h4: decode = 7'b1001100;
            4'h5: decode = 7'b0100100;
            4'h6: decode = 7'b0100000;
            4'h7: decode = 7'b0001111;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0001100;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b1100000;
            4'hC: decode = 7'b0110001;
            4'hD: decode = 7'b1000010;
            4'hE: decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    always_comb begin
        shadow_d      = load ? value : shadow_q;
        scan_wrap     = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d    = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        idx_d         = idx_q;
        if (scan_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        blink_wrap    = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_wrap ? ~blink_phase_q : blink_phase_q;
    end

    // Outputs use the post-edge scan index and blink phase so that a wrap is
    // visible on the wrap edge itself, while the digits come from the current shadow.
    always_comb begin
        seg_d     = '1;
        dp_n_d    = '1;
        seg_mux_d = '1;
        dp_mux_d  = 1'b1;
        an_d      = '1;
        zero_run  = 1'b1;
        lz_blank  = 1'b0;
        bl_blank  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (shadow_q[4*i +: 4] == 4'h0);
            lz_blank = lz_en & zero_run & (i != 0);
            bl_blank = blink_phase_d & blink_en[i];
            seg_d[7*i +: 7] = (lz_blank | bl_blank) ? 7'h7F : decode(shadow_q[4*i +: 4]);
            dp_n_d[i]       = bl_blank | ~dp[i];
            if (idx_d == IDX_W'(i)) begin
                seg_mux_d = seg_d[7*i +: 7];
                dp_mux_d  = dp_n_d[i];
                an_d[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            scan_cnt_q    <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            seg_q         <= '1;
            dp_n_q        <= '1;
            seg_mux_q     <= '1;
            dp_mux_q      <= 1'b1;
            an_q          <= '1;
        end else begin
            shadow_q      <= shadow_d;
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
            seg_mux_q     <= seg_mux_d;
            dp_mux_q      <= dp_mux_d;
            an_q          <= an_d;
        end
    end

    assign hex_seg  = seg_q;
    assign hex_dp_n = dp_n_q;
    assign seg_mux  = seg_mux_q;
    assign dp_mux_n = dp_mux_q;
    assign an_n     = an_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl with DIGITS=4, SCAN_DIV=4, BLINK_DIV=8: a cycle
// scoreboard over every step plus constant-table and corner-case checks.
module tb_hex_display_ctrl;

    localparam int DIGITS = 4;
    localparam int SDIV   = 4;
    localparam int BDIV   = 8;
    localparam int W      = 44;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load, lz_en;
    logic [3:0]  dp, blink_en;
    logic [27:0] hex_seg;
    logic [3:0]  hex_dp_n;
    logic [6:0]  seg_mux;
    logic        dp_mux_n;
    logic [3:0]  an_n;

    hex_display_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SDIV), .BLINK_DIV(BDIV)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .lz_en(lz_en),
        .dp(dp), .blink_en(blink_en), .hex_seg(hex_seg), .hex_dp_n(hex_dp_n),
        .seg_mux(seg_mux), .dp_mux_n(dp_mux_n), .an_n(an_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic        lz;
        logic [3:0]  dp;
        logic [27:0] exp_seg;
        logic [3:0]  exp_dp_n;
    } vec_t;

    vec_t          vecs[8];
    logic [6:0]    seg_tab[16];
    logic [W-1:0]  exp_q[$];
    logic [15:0]   m_shadow;
    int            m_n;
    int            n_tests = 0;
    int            n_fail  = 0;

    function automatic logic [W-1:0] model_out(input logic [15:0] sh, input logic lz,
                                               input logic [3:0] d, input logic [3:0] b, input int n);
        logic [27:0] s;
        logic [3:0]  dn;
        logic [6:0]  f;
        int          idx;
        logic        ph, blank;
        idx = (n / SDIV) % DIGITS;
        ph  = ((n / BDIV) % 2) == 1;
        for (int i = 0; i < DIGITS; i++) begin
            blank = (lz && i > 0 && (sh >> (4 * i)) == 16'h0) || (ph && b[i]);
            f = seg_tab[sh[4*i +: 4]];
            s[7*i +: 7] = blank ? 7'h7F : f;
            dn[i] = (ph && b[i]) ? 1'b1 : ~d[i];
        end
        return {s, dn, s[7*idx +: 7], dn[idx], ~(4'b0001 << idx)};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [15:0] v, input logic l, input logic lz,
                        input logic [3:0] d, input logic [3:0] b);
        logic [W-1:0] e, got;
        rst_n = r; value = v; load = l; lz_en = lz; dp = d; blink_en = b;
        if (!r) begin
            e = '1;
            m_shadow = 16'h0;
            m_n = 0;
        end else begin
            m_n++;
            e = model_out(m_shadow, lz, d, b, m_n);
            if (l) m_shadow = v;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = {hex_seg, hex_dp_n, seg_mux, dp_mux_n, an_n};
        e = exp_q.pop_front();
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL sb n=%0d: got %h expected %h", m_n, got, e);
        end
        @(negedge clk);
    endtask

    initial begin
        int run, guard;
        logic [3:0] prev_an;
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                    7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        vecs[0] = '{16'h00A5, 1'b0, 4'b0000, {7'b0000001, 7'b0000001, 7'b0001000, 7'b0100100}, 4'b1111};
        vecs[1] = '{16'h00A5, 1'b1, 4'b0000, {7'b1111111, 7'b1111111, 7'b0001000, 7'b0100100}, 4'b1111};
        vecs[2] = '{16'h0000, 1'b1, 4'b0000, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1111};
        vecs[3] = '{16'h1234, 1'b1, 4'b0101, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1010};
        vecs[4] = '{16'h0F00, 1'b1, 4'b1000, {7'b1111111, 7'b0111000, 7'b0000001, 7'b0000001}, 4'b0111};
        vecs[5] = '{16'hBCDE, 1'b0, 4'b0000, {7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000}, 4'b1111};
        vecs[6] = '{16'h6789, 1'b0, 4'b0000, {7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100}, 4'b1111};
        vecs[7] = '{16'h0000, 1'b0, 4'b0011, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1100};
        m_shadow = 16'h0; m_n = 0;
        rst_n = 1'b0; value = '0; load = 1'b0; lz_en = 1'b0; dp = '0; blink_en = '0;
        @(negedge clk);

        // Reset state, then first edge out of reset.
        step(0, 16'h0, 0, 0, 0, 0);
        step(0, 16'h0, 0, 0, 0, 0);
        check("reset_seg", {4'h0, hex_seg}, 32'h0FFFFFFF);
        check("reset_an", {28'h0, an_n}, 32'hF);
        step(1, 16'h0, 0, 0, 0, 0);
        check("first_an", {28'h0, an_n}, 32'hE);
        check("first_mux", {25'h0, seg_mux}, {25'h0, 7'b0000001});

        // Constant decode table.
        for (int k = 0; k < 8; k++) begin
            step(1, vecs[k].value, 1, vecs[k].lz, vecs[k].dp, 0);
            step(1, vecs[k].value, 0, vecs[k].lz, vecs[k].dp, 0);
            check($sformatf("tbl_seg%0d", k), {4'h0, hex_seg}, {4'h0, vecs[k].exp_seg});
            check($sformatf("tbl_dp%0d", k), {28'h0, hex_dp_n}, {28'h0, vecs[k].exp_dp_n});
        end

        // Scan rotation: every full an_n window lasts exactly SDIV cycles.
        prev_an = an_n; run = 0; guard = 0;
        for (int c = 0; c < 30; c++) begin
            step(1, 16'h0, 0, 0, 0, 0);
            if (an_n == prev_an) run++;
            else begin
                if (guard > 0) check("scan_hold", run + 1, SDIV);
                guard++;
                run = 0;
            end
            prev_an = an_n;
        end

        // Blink on digit 1 with its dp lit.
        step(1, 16'h1234, 1, 0, 4'b0010, 4'b0010);
        for (int c = 0; c < 24; c++) begin
            step(1, 16'h1234, 0, 0, 4'b0010, 4'b0010);
            if (((m_n / BDIV) % 2) == 1) begin
                check("blink_off_seg", {25'h0, hex_seg[7 +: 7]}, {25'h0, 7'h7F});
                check("blink_off_dp", {31'h0, hex_dp_n[1]}, 32'h1);
            end else begin
                check("blink_on_seg", {25'h0, hex_seg[7 +: 7]}, {25'h0, 7'b0000110});
                check("blink_on_dp", {31'h0, hex_dp_n[1]}, 32'h0);
            end
            check("blink_d0", {25'h0, hex_seg[6:0]}, {25'h0, 7'b1001100});
        end

        // Load on the same edge as a scan wrap.
        guard = 0;
        while (((m_n + 1) % SDIV) != 0 && guard < 10) begin
            step(1, 16'h0, 0, 0, 0, 0);
            guard++;
        end
        step(1, 16'hFFFF, 1, 0, 0, 0);
        step(1, 16'hFFFF, 0, 0, 0, 0);
        check("wrap_load_mux", {25'h0, seg_mux}, {25'h0, 7'b0111000});
        check("wrap_load_an", {28'h0, an_n}, {28'h0, ~(4'b0001 << ((m_n / SDIV) % DIGITS))});

        // Reset during scan index 2, with a load asserted on that edge.
        guard = 0;
        while (((m_n / SDIV) % DIGITS) != 2 && guard < 20) begin
            step(1, 16'hFFFF, 0, 0, 0, 0);
            guard++;
        end
        step(0, 16'h5555, 1, 0, 4'hF, 0);
        check("midrst_seg", {4'h0, hex_seg}, 32'h0FFFFFFF);
        check("midrst_mux", {24'h0, seg_mux, dp_mux_n}, 32'hFF);
        check("midrst_an", {28'h0, an_n}, 32'hF);
        step(1, 16'h0, 0, 0, 0, 0);
        check("postrst_an", {28'h0, an_n}, 32'hE);
        check("postrst_seg", {4'h0, hex_seg}, {4'h0, {4{7'b0000001}}});

        // Random traffic with occasional resets.
        for (int c = 0; c < 200; c++) begin
            step(($urandom_range(0, 39) != 0), 16'($urandom_range(0, 65535)),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
